// File: rtl/simd_pe_core_if.sv
// Controller-side bus of one SIMD processing element: bank write port,
// operation issue, bank read port and status.
interface simd_pe_core_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
);
    localparam int AW    = $clog2(DEPTH);
    localparam int ACC_W = 2*DATA_W + AW;

    logic              WR_EN;
    logic [1:0]        WR_SEL;
    logic [AW-1:0]     WR_ADDR;
    logic [DATA_W-1:0] WR_DATA;
    logic              START;
    logic [1:0]        OP;
    logic [1:0]        RD_SEL;
    logic [AW-1:0]     RD_ADDR;
    logic [DATA_W-1:0] RD_DATA;
    logic [ACC_W-1:0]  ACC_OUT;
    logic              BUSY;
    logic              DONE_OPS;

    modport master (
        output WR_EN, WR_SEL, WR_ADDR, WR_DATA, START, OP, RD_SEL, RD_ADDR,
        input  RD_DATA, ACC_OUT, BUSY, DONE_OPS
    );

    modport slave (
        input  WR_EN, WR_SEL, WR_ADDR, WR_DATA, START, OP, RD_SEL, RD_ADDR,
        output RD_DATA, ACC_OUT, BUSY, DONE_OPS
    );
endinterface

// File: rtl/simd_pe_core.sv
// SIMD processing element: three local banks A/B/C and a one-element-per-cycle
// datapath that either reduces A*B into a wide accumulator or writes C element-wise.
module simd_pe_core #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic           CLK,
    input  logic           RSTN,
    simd_pe_core_if.slave  bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int ACC_W = 2*DATA_W + AW;

    typedef enum logic [1:0] {OP_DOT = 2'd0, OP_ADD = 2'd1, OP_MUL = 2'd2, OP_MACC = 2'd3} op_t;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                   state_reg;
    op_t                      op_reg;
    logic [AW-1:0]            idx_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic                     busy_reg;
    logic                     done_reg;
    logic [DATA_W-1:0]        rd_data_reg;

    logic [DATA_W-1:0] bank_a [DEPTH];
    logic [DATA_W-1:0] bank_b [DEPTH];
    logic [DATA_W-1:0] bank_c [DEPTH];

    logic [DATA_W-1:0]         a_cur, b_cur, c_cur, c_next, rd_word;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic                       port_write, dp_write_c;

    assign a_cur    = bank_a[idx_reg];
    assign b_cur    = bank_b[idx_reg];
    assign c_cur    = bank_c[idx_reg];
    assign prod     = $signed(a_cur) * $signed(b_cur);
    assign prod_ext = ACC_W'(prod);

    assign port_write = (state_reg == IDLE) && bus.WR_EN;
    assign dp_write_c = (state_reg == RUN) && (op_reg != OP_DOT);

    always_comb begin
        c_next = a_cur + b_cur;
        case (op_reg)
            OP_MUL:  c_next = prod[DATA_W-1:0];
            OP_MACC: c_next = c_cur + prod[DATA_W-1:0];
            default: c_next = a_cur + b_cur;
        endcase
    end

    // One register slice per word; port writes and datapath writes never
    // coincide because the port is only honoured in IDLE.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) begin
                    bank_a[gi] <= '0;
                    bank_b[gi] <= '0;
                    bank_c[gi] <= '0;
                end else begin
                    if (port_write && bus.WR_SEL == 2'd0 && bus.WR_ADDR == AW'(gi))
                        bank_a[gi] <= bus.WR_DATA;
                    if (port_write && bus.WR_SEL == 2'd1 && bus.WR_ADDR == AW'(gi))
                        bank_b[gi] <= bus.WR_DATA;
                    if (dp_write_c && idx_reg == AW'(gi))
                        bank_c[gi] <= c_next;
                    else if (port_write && bus.WR_SEL == 2'd2 && bus.WR_ADDR == AW'(gi))
                        bank_c[gi] <= bus.WR_DATA;
                end
            end
        end
    endgenerate

    always_comb begin
        rd_word = '0;
        case (bus.RD_SEL)
            2'd0:    rd_word = bank_a[bus.RD_ADDR];
            2'd1:    rd_word = bank_b[bus.RD_ADDR];
            2'd2:    rd_word = bank_c[bus.RD_ADDR];
            default: rd_word = '0;
        endcase
    end

    // Samples the pre-edge bank contents, so reads see data before any
    // datapath write landing on the same edge.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) rd_data_reg <= '0;
        else       rd_data_reg <= rd_word;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_reg <= IDLE;
            op_reg    <= OP_DOT;
            idx_reg   <= '0;
            acc_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.START) begin
                        state_reg <= RUN;
                        busy_reg  <= 1'b1;
                        op_reg    <= op_t'(bus.OP);
                        idx_reg   <= '0;
                        if (op_t'(bus.OP) == OP_DOT) acc_reg <= '0;
                    end
                end
                RUN: begin
                    if (op_reg == OP_DOT) acc_reg <= acc_reg + prod_ext;
                    idx_reg <= idx_reg + 1'b1;
                    if (idx_reg == AW'(DEPTH-1)) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.RD_DATA  = rd_data_reg;
    assign bus.ACC_OUT  = acc_reg;
    assign bus.BUSY     = busy_reg;
    assign bus.DONE_OPS = done_reg;
endmodule

// File: tb/tb_simd_pe_core.sv
// Randomised scoreboard bench for simd_pe_core: stimulus pushes expected
// read data and completion results; a negedge monitor pops and compares.
module tb_simd_pe_core;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int AW     = $clog2(DEPTH);
    localparam int ACC_W  = 2*DATA_W + AW;

    logic CLK = 1'b0;
    logic RSTN = 1'b0;
    always #5 CLK = ~CLK;

    simd_pe_core_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus();
    simd_pe_core #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (.CLK(CLK), .RSTN(RSTN), .bus(bus));

    typedef struct {
        logic [ACC_W-1:0] acc;
        int               cyc;
    } done_exp_t;

    logic [DATA_W-1:0]       ma [DEPTH];
    logic [DATA_W-1:0]       mb [DEPTH];
    logic [DATA_W-1:0]       mc [DEPTH];
    logic signed [ACC_W-1:0] macc;

    done_exp_t         done_q [$];
    logic [DATA_W-1:0] rd_q [$];
    done_exp_t         mon_e;

    int   n_vec = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic rd_req = 1'b0;
    logic rd_valid = 1'b0;
    logic prev_done = 1'b0;

    always @(posedge CLK) begin
        cyc++;
        if (!RSTN) rd_valid <= 1'b0;
        else       rd_valid <= rd_req;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        if (RSTN) begin
            if (bus.DONE_OPS) begin
                if (done_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL done_unexpected: got DONE_OPS=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    mon_e = done_q.pop_front();
                    check("acc_at_done", bus.ACC_OUT, mon_e.acc);
                    check("done_latency", cyc, mon_e.cyc);
                    check("done_width", prev_done, 0);
                    check("busy_at_done", bus.BUSY, 0);
                    $display("done: acc=0x%0h cycle=%0d", bus.ACC_OUT, cyc);
                end
            end
            if (rd_valid) begin
                if (rd_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got read with empty queue, data 0x%0h", bus.RD_DATA);
                end else begin
                    check("rd_data", bus.RD_DATA, rd_q.pop_front());
                end
            end
        end
        prev_done = bus.DONE_OPS;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] mread(input logic [1:0] sel, input int addr);
        case (sel)
            2'd0:    return ma[addr];
            2'd1:    return mb[addr];
            2'd2:    return mc[addr];
            default: return '0;
        endcase
    endfunction

    task automatic mwrite(input logic [1:0] sel, input int addr, input logic [DATA_W-1:0] data);
        case (sel)
            2'd0: ma[addr] = data;
            2'd1: mb[addr] = data;
            2'd2: mc[addr] = data;
            default: ;
        endcase
    endtask

    task automatic mclear();
        for (int i = 0; i < DEPTH; i++) begin
            ma[i] = '0; mb[i] = '0; mc[i] = '0;
        end
        macc = '0;
    endtask

    task automatic wr(input logic [1:0] sel, input int addr, input logic [DATA_W-1:0] data);
        bus.WR_SEL = sel; bus.WR_ADDR = AW'(addr); bus.WR_DATA = data; bus.WR_EN = 1'b1;
        tick();
        bus.WR_EN = 1'b0;
        mwrite(sel, addr, data);
    endtask

    task automatic rd(input logic [1:0] sel, input int addr);
        bus.RD_SEL = sel; bus.RD_ADDR = AW'(addr);
        rd_q.push_back(mread(sel, addr));
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    // Reference semantics: the whole operation as one array computation.
    task automatic model_op(input logic [1:0] op);
        logic signed [ACC_W-1:0] sum;
        longint p;
        sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            p = longint'($signed(ma[i])) * longint'($signed(mb[i]));
            case (op)
                2'd0: sum += ACC_W'($signed(ma[i])) * ACC_W'($signed(mb[i]));
                2'd1: mc[i] = ma[i] + mb[i];
                2'd2: mc[i] = p[DATA_W-1:0];
                default: mc[i] = mc[i] + p[DATA_W-1:0];
            endcase
        end
        if (op == 2'd0) macc = sum;
    endtask

    task automatic start_op(input logic [1:0] op, input bit do_wr, input logic [1:0] wsel,
                            input int waddr, input logic [DATA_W-1:0] wdata);
        done_exp_t e;
        bus.OP = op; bus.START = 1'b1;
        if (do_wr) begin
            bus.WR_SEL = wsel; bus.WR_ADDR = AW'(waddr); bus.WR_DATA = wdata; bus.WR_EN = 1'b1;
        end
        tick();
        bus.START = 1'b0; bus.WR_EN = 1'b0;
        if (do_wr) mwrite(wsel, waddr, wdata);
        model_op(op);
        e.acc = macc;
        e.cyc = cyc + DEPTH;
        done_q.push_back(e);
        check("busy_after_start", bus.BUSY, 1);
        $display("start: op=%0d wr=%0d", op, do_wr);
    endtask

    task automatic wait_done();
        for (int k = 0; k < DEPTH + 8 && done_q.size() != 0; k++) tick();
        if (done_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL done_timeout: got no DONE_OPS expected one within %0d cycles", DEPTH + 8);
            done_q.delete();
        end
        tick();
    endtask

    task automatic read_c_all();
        for (int i = 0; i < DEPTH; i++) rd(2'd2, i);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.WR_EN = 1'b0; bus.WR_SEL = 2'd3; bus.WR_ADDR = '0; bus.WR_DATA = '0;
        bus.START = 1'b0; bus.OP = 2'd0; bus.RD_SEL = 2'd3; bus.RD_ADDR = '0;
        mclear();

        // Reset state
        #12;
        check("rst_busy", bus.BUSY, 0);
        check("rst_done", bus.DONE_OPS, 0);
        check("rst_acc", bus.ACC_OUT, 0);
        check("rst_rd", bus.RD_DATA, 0);
        tick();
        RSTN = 1'b1;
        for (int s = 0; s < 4; s++)
            for (int i = 0; i < DEPTH; i++) rd(2'(s), i);

        // DOT directed
        for (int i = 0; i < DEPTH; i++) begin
            wr(2'd0, i, DATA_W'(i + 1));
            wr(2'd1, i, 32'd2);
        end
        start_op(2'd0, 1'b0, 2'd3, 0, '0);
        wait_done();
        check("dot_272", bus.ACC_OUT, 272);
        for (int i = 0; i < DEPTH; i++) begin
            wr(2'd0, i, 32'hFFFF_FFFF);
            wr(2'd1, i, 32'hFFFF_FFFF);
        end
        start_op(2'd0, 1'b0, 2'd3, 0, '0);
        wait_done();
        check("dot_neg1", bus.ACC_OUT, 16);

        // ADD and MUL leave the accumulator alone
        for (int i = 0; i < DEPTH; i++) begin
            wr(2'd0, i, 32'hFFFF_FFFF);
            wr(2'd1, i, 32'd2);
        end
        start_op(2'd1, 1'b0, 2'd3, 0, '0);
        wait_done();
        read_c_all();
        check("acc_hold_add", bus.ACC_OUT, 16);
        for (int i = 0; i < DEPTH; i++) begin
            wr(2'd0, i, 32'hFFFF_FFFD);
            wr(2'd1, i, 32'd5);
        end
        start_op(2'd2, 1'b0, 2'd3, 0, '0);
        wait_done();
        read_c_all();
        rd(2'd2, 3);
        check("mul_const", bus.RD_DATA, 32'hFFFF_FFF1);
        check("acc_hold_mul", bus.ACC_OUT, 16);

        // MACC twice
        for (int i = 0; i < DEPTH; i++) begin
            wr(2'd2, i, 32'd10);
            wr(2'd0, i, 32'd3);
            wr(2'd1, i, 32'd4);
        end
        start_op(2'd3, 1'b0, 2'd3, 0, '0);
        wait_done();
        rd(2'd2, 5);
        check("macc_22", bus.RD_DATA, 22);
        start_op(2'd3, 1'b0, 2'd3, 0, '0);
        wait_done();
        read_c_all();
        rd(2'd2, 0);
        check("macc_34", bus.RD_DATA, 34);

        // Write and START while busy are dropped
        start_op(2'd1, 1'b0, 2'd3, 0, '0);
        repeat (3) tick();
        bus.WR_SEL = 2'd0; bus.WR_ADDR = '0; bus.WR_DATA = 32'h55; bus.WR_EN = 1'b1;
        bus.OP = 2'd1; bus.START = 1'b1;
        tick();
        bus.WR_EN = 1'b0; bus.START = 1'b0;
        wait_done();
        repeat (DEPTH + 2) tick();
        rd(2'd0, 0);
        check("busy_wr_dropped", bus.RD_DATA, 3);
        read_c_all();

        // Randomised operations, some with a write in the START cycle
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < DEPTH; i++) begin
                wr(2'd0, i, $urandom);
                wr(2'd1, i, $urandom);
                wr(2'd2, i, $urandom);
            end
            start_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)), $urandom_range(0, DEPTH - 1), $urandom);
            wait_done();
            read_c_all();
            rd(2'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1));
        end

        // Reset in the middle of a DOT
        for (int i = 0; i < DEPTH; i++) begin
            wr(2'd0, i, $urandom);
            wr(2'd1, i, $urandom);
        end
        start_op(2'd0, 1'b0, 2'd3, 0, '0);
        repeat (7) tick();
        RSTN = 1'b0;
        #1;
        check("rst_mid_busy", bus.BUSY, 0);
        check("rst_mid_acc", bus.ACC_OUT, 0);
        check("rst_mid_done", bus.DONE_OPS, 0);
        done_q.delete();
        rd_q.delete();
        mclear();
        tick();
        tick();
        RSTN = 1'b1;
        repeat (DEPTH + 2) tick();
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < DEPTH; i++) rd(2'(s), i);
        for (int i = 0; i < DEPTH; i++) begin
            wr(2'd0, i, DATA_W'(i + 1));
            wr(2'd1, i, 32'd2);
        end
        start_op(2'd0, 1'b0, 2'd3, 0, '0);
        wait_done();
        check("post_rst_dot", bus.ACC_OUT, 272);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
